instr_encoder: RTL

Sequential MIPS instruction encoder and program loader. It accepts symbolic instruction requests (mnemonic code plus register and immediate fields) over a valid/ready handshake. It packs each request into the 32-bit machine word that the core's control decoder expects, and writes the words into consecutive instruction-memory locations. The block is the bench/boot-side producer of the instruction stream that the SCPU fetches and decodes. It also expands the `li` pseudo-instruction into a `lui`/`ori` pair.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write channels of the instruction encoder.
// The DUT takes the slave side; the program source takes the master side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_mnem;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [31:0]       req_imm;
  logic [25:0]       req_target;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output req_valid, req_mnem, req_rs, req_rt, req_rd, req_imm, req_target,
    input  req_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  req_valid, req_mnem, req_rs, req_rt, req_rd, req_imm, req_target,
    output req_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS requests into machine words and writes them to consecutive IM slots.
// One cycle accept-to-write; li stalls req_ready one cycle for its ori word; ready drops when full.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clear,
  instr_encoder_if.slave  bus,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            err,
  output logic            ovf
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [4:0] M_ADD  = 5'd0;
  localparam logic [4:0] M_SUB  = 5'd1;
  localparam logic [4:0] M_AND  = 5'd2;
  localparam logic [4:0] M_OR   = 5'd3;
  localparam logic [4:0] M_SLT  = 5'd4;
  localparam logic [4:0] M_SLTU = 5'd5;
  localparam logic [4:0] M_ADDU = 5'd6;
  localparam logic [4:0] M_SUBU = 5'd7;
  localparam logic [4:0] M_NOR  = 5'd8;
  localparam logic [4:0] M_JR   = 5'd9;
  localparam logic [4:0] M_JALR = 5'd10;
  localparam logic [4:0] M_ADDI = 5'd11;
  localparam logic [4:0] M_ORI  = 5'd12;
  localparam logic [4:0] M_LW   = 5'd13;
  localparam logic [4:0] M_SW   = 5'd14;
  localparam logic [4:0] M_BEQ  = 5'd15;
  localparam logic [4:0] M_BNE  = 5'd16;
  localparam logic [4:0] M_ANDI = 5'd17;
  localparam logic [4:0] M_SLTI = 5'd18;
  localparam logic [4:0] M_LUI  = 5'd19;
  localparam logic [4:0] M_J    = 5'd20;
  localparam logic [4:0] M_JAL  = 5'd21;
  localparam logic [4:0] M_LI   = 5'd22;
  localparam logic [4:0] M_NOP  = 5'd23;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  typedef enum logic {
    S_IDLE,
    S_LI2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              err_nxt, ovf_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic [31:0]       li_hold, li_hold_nxt;

  logic [31:0]       word0;
  logic [31:0]       li_word2;
  logic              legal;
  logic              is_li;
  logic              accept;
  logic              room2;
  logic [ADDR_W-1:0] wr_addr;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  always_comb begin
    word0 = 32'h0;
    legal = 1'b1;
    is_li = 1'b0;
    case (bus.req_mnem)
      M_ADD:   word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h20);
      M_SUB:   word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h22);
      M_AND:   word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h24);
      M_OR:    word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h25);
      M_SLT:   word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h2A);
      M_SLTU:  word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h2B);
      M_ADDU:  word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h21);
      M_SUBU:  word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h23);
      M_NOR:   word0 = r_type(bus.req_rs, bus.req_rt, bus.req_rd, 6'h27);
      M_JR:    word0 = {6'h00, bus.req_rs, 15'h0000, 6'h08};
      M_JALR:  word0 = {6'h00, bus.req_rs, 5'h00, bus.req_rd, 5'h00, 6'h09};
      M_ADDI:  word0 = i_type(OP_ADDI, bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_ORI:   word0 = i_type(OP_ORI,  bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_LW:    word0 = i_type(OP_LW,   bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_SW:    word0 = i_type(OP_SW,   bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_BEQ:   word0 = i_type(OP_BEQ,  bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_BNE:   word0 = i_type(OP_BNE,  bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_ANDI:  word0 = i_type(OP_ANDI, bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_SLTI:  word0 = i_type(OP_SLTI, bus.req_rs, bus.req_rt, bus.req_imm[15:0]);
      M_LUI:   word0 = i_type(OP_LUI,  5'h00,      bus.req_rt, bus.req_imm[15:0]);
      M_J:     word0 = {OP_J,   bus.req_target};
      M_JAL:   word0 = {OP_JAL, bus.req_target};
      M_LI: begin
        word0 = i_type(OP_LUI, 5'h00, bus.req_rt, bus.req_imm[31:16]);
        is_li = 1'b1;
      end
      M_NOP:   word0 = 32'h0;
      default: legal = 1'b0;
    endcase
  end

  assign li_word2 = i_type(OP_ORI, bus.req_rt, bus.req_rt, bus.req_imm[15:0]);

  assign full          = (count == CNT_W'(DEPTH));
  assign bus.req_ready = (state == S_IDLE) && !full;
  assign accept        = bus.req_valid && bus.req_ready;
  // The ori half of li only gets a slot if two are free before the lui is written.
  assign room2         = (count <= CNT_W'(DEPTH - 2));
  assign wr_addr       = ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    err_nxt     = err;
    ovf_nxt     = ovf;
    we_nxt      = 1'b0;
    addr_nxt    = bus.im_addr;
    wdata_nxt   = bus.im_wdata;
    li_hold_nxt = li_hold;

    if (clear) begin
      state_nxt   = S_IDLE;
      count_nxt   = '0;
      err_nxt     = 1'b0;
      ovf_nxt     = 1'b0;
      addr_nxt    = ADDR_W'(BASE_ADDR);
      wdata_nxt   = 32'h0;
      li_hold_nxt = 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!legal) begin
              err_nxt = 1'b1;
            end else begin
              we_nxt    = 1'b1;
              addr_nxt  = wr_addr;
              wdata_nxt = word0;
              count_nxt = count + 1'b1;
              if (is_li) begin
                if (room2) begin
                  state_nxt   = S_LI2;
                  li_hold_nxt = li_word2;
                end else begin
                  ovf_nxt = 1'b1;
                end
              end
            end
          end
        end
        S_LI2: begin
          we_nxt    = 1'b1;
          addr_nxt  = wr_addr;
          wdata_nxt = li_hold;
          count_nxt = count + 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      count        <= '0;
      err          <= 1'b0;
      ovf          <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= ADDR_W'(BASE_ADDR);
      bus.im_wdata <= 32'h0;
      li_hold      <= 32'h0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      err          <= err_nxt;
      ovf          <= ovf_nxt;
      bus.im_we    <= we_nxt;
      bus.im_addr  <= addr_nxt;
      bus.im_wdata <= wdata_nxt;
      li_hold      <= li_hold_nxt;
    end
  end

endmodule
